// File: rtl/piso_pkg.sv
// Shared types and helpers for the framed parallel-to-serial transmitter.
package piso_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_STOP  = 3'd3,
    ST_END   = 3'd4
  } state_t;

  // Zero-extension of a narrower word leaves its XOR reduction unchanged.
  function automatic logic parity_bit(input logic [63:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/piso_scl_div.sv
// Half-period divider: tick fires on the last sclk of every DIV-cycle window.
module piso_scl_div #(
  parameter int DIV = 2
) (
  input  logic sclk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sclk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/piso_frame_tx.sv
// Framed serializer: START, DATA_W data bits, optional parity, STOP on a scl/sda pair.
module piso_frame_tx
  import piso_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV        = 2,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              d_valid,
  output logic              d_ready,
  output logic              scl,
  output logic              sda,
  output logic              busy,
  output logic              done
);

  localparam int N     = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int BW    = DATA_W + 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N);

  state_t            state;
  logic [BW-1:0]     shift;
  logic [BW-1:0]     load;
  logic [DATA_W-1:0] ordered;
  logic [CNT_W-1:0]  bit_cnt;
  logic              pend;
  logic              tick;
  logic              accept;

  assign accept = d_valid && d_ready;

  // Buffer is pre-ordered so the line always takes bit 0; parity sits above the data.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ordered[i] = (MSB_FIRST != 0) ? data[DATA_W-1-i] : data[i];
    end
    load = {parity_bit(64'(data), PARITY_ODD != 0), ordered};
  end

  piso_scl_div #(.DIV(DIV)) u_div (
    .sclk  (sclk),
    .rst   (rst),
    .clear (state == ST_IDLE),
    .tick  (tick)
  );

  // pend marks the cycle after a scl fall, when sda is allowed to move.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state   <= ST_IDLE;
      scl     <= 1'b1;
      sda     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      d_ready <= 1'b0;
      pend    <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          scl     <= 1'b1;
          sda     <= 1'b1;
          busy    <= 1'b0;
          pend    <= 1'b0;
          bit_cnt <= '0;
          if (accept) begin
            shift   <= load;
            d_ready <= 1'b0;
            busy    <= 1'b1;
            sda     <= 1'b0;
            state   <= ST_START;
          end else begin
            d_ready <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            scl   <= 1'b0;
            pend  <= 1'b1;
            state <= ST_BIT;
          end
        end
        ST_BIT: begin
          if (pend) begin
            sda     <= shift[0];
            shift   <= {1'b0, shift[BW-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            pend    <= 1'b0;
          end else if (tick) begin
            if (!scl) begin
              scl <= 1'b1;
            end else begin
              scl  <= 1'b0;
              pend <= 1'b1;
              if (bit_cnt == LAST_CNT) begin
                state <= ST_STOP;
              end
            end
          end
        end
        ST_STOP: begin
          if (pend) begin
            sda  <= 1'b0;
            pend <= 1'b0;
          end else if (tick) begin
            scl   <= 1'b1;
            state <= ST_END;
          end
        end
        ST_END: begin
          if (tick) begin
            sda     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            d_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          scl     <= 1'b1;
          sda     <= 1'b1;
          busy    <= 1'b0;
          d_ready <= 1'b0;
          pend    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
